// File: rtl/ifu_pkg.sv
// Shared widths, FSM state type and small helpers for the instruction-fetch refill path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ifu_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int LINE_WIDTH   = 128;
  localparam int OFFSET_WIDTH = 4;
  localparam int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [LINE_WIDTH-1:0] line_t;
  typedef logic [TAG_WIDTH-1:0]  tag_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    FILL,
    RESP
  } ifu_state_e;

  // Line tag is the address with the in-line byte offset dropped.
  function automatic tag_t addr_to_tag(input addr_t addr);
    return addr[ADDR_WIDTH-1:OFFSET_WIDTH];
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ifu_timeout_cnt.sv
// Cycle counter that flags when a memory wait has lasted MAX_CNT cycles.
// Latency: expired is a registered compare; it rises MAX_CNT enabled cycles after clear.
// Backpressure: none; clear wins over enable, count holds at MAX_CNT once expired.
// Ports: clk/rst_n (async active-low), clear (restart from 0), enable (count this cycle),
//        expired (count has reached MAX_CNT).
module ifu_timeout_cnt #(
  parameter int MAX_CNT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired = (cnt_q == W'(MAX_CNT));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ifu_refill_ctrl.sv
// Instruction-fetch refill controller: cache lookup, memory refill on miss, one request in flight.
// Latency: response 2 cycles after request accept on a hit, 2 cycles after the matching memory line on a miss.
// Backpressure: memory request and CPU response are held stable until their ready is seen.
// Ports: Clock/Rst (async active-low); cpu_req*/cpu_rsp* CPU side; cache_lookup*/cache_hitIn/
//        cache_lineIn/cache_fill* cache side; mem_req*/mem_rsp* memory side; hit/miss statistics.
module ifu_refill_ctrl
  import ifu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic                  cpu_reqValidIn,
  output logic                  cpu_reqReadyOut,
  input  logic [ADDR_WIDTH-1:0] cpu_reqAddrIn,
  output logic                  cpu_rspValidOut,
  input  logic                  cpu_rspReadyIn,
  output logic [ADDR_WIDTH-1:0] cpu_rspAddrOut,
  output logic [LINE_WIDTH-1:0] cpu_rspInsLineOut,
  output logic                  cpu_rspErrOut,
  output logic                  cache_lookupValidOut,
  output logic [ADDR_WIDTH-1:0] cache_lookupAddrOut,
  input  logic                  cache_hitIn,
  input  logic [LINE_WIDTH-1:0] cache_lineIn,
  output logic                  cache_fillValidOut,
  output logic [TAG_WIDTH-1:0]  cache_fillTagOut,
  output logic [LINE_WIDTH-1:0] cache_fillLineOut,
  output logic                  mem_reqTagValidOut,
  input  logic                  mem_reqReadyIn,
  output logic [TAG_WIDTH-1:0]  mem_reqTagOut,
  input  logic                  mem_rspInsLineValidIn,
  input  logic [TAG_WIDTH-1:0]  mem_rspTagIn,
  input  logic [LINE_WIDTH-1:0] mem_rspInsLineIn,
  output logic [15:0]           hitCntOut,
  output logic [15:0]           missCntOut
);

  ifu_state_e  state_q, state_d;
  addr_t       addr_q, addr_d;
  line_t       line_q, line_d;
  logic        err_q, err_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  tag_t pend_tag;
  logic tmo_clear;
  logic tmo_expired;
  logic mem_match;

  assign pend_tag  = addr_to_tag(addr_q);
  assign mem_match = mem_rspInsLineValidIn && (mem_rspTagIn == pend_tag);

  ifu_timeout_cnt #(
    .MAX_CNT (MEM_TIMEOUT)
  ) u_timeout_cnt (
    .clk     (Clock),
    .rst_n   (Rst),
    .clear   (tmo_clear),
    .enable  (state_q == MISS_WAIT),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    line_d     = line_q;
    err_d      = err_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    tmo_clear  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_reqValidIn) begin
          // Clearing the line here leaves a timed-out response with an all-zero line.
          addr_d  = cpu_reqAddrIn;
          line_d  = '0;
          err_d   = 1'b0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (cache_hitIn) begin
          line_d    = cache_lineIn;
          hit_cnt_d = sat_inc16(hit_cnt_q);
          state_d   = RESP;
        end else begin
          miss_cnt_d = sat_inc16(miss_cnt_q);
          state_d    = MISS_REQ;
        end
      end
      MISS_REQ: begin
        if (mem_reqReadyIn) begin
          tmo_clear = 1'b1;
          state_d   = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        // A matching line arriving in the expiry cycle is still taken.
        if (mem_match) begin
          line_d  = mem_rspInsLineIn;
          state_d = FILL;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      FILL: begin
        state_d = RESP;
      end
      RESP: begin
        if (cpu_rspReadyIn) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      line_q     <= '0;
      err_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      line_q     <= line_d;
      err_q      <= err_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign cpu_reqReadyOut      = (state_q == IDLE);
  assign cpu_rspValidOut      = (state_q == RESP);
  assign cpu_rspAddrOut       = addr_q;
  assign cpu_rspInsLineOut    = line_q;
  assign cpu_rspErrOut        = (state_q == RESP) && err_q;
  assign cache_lookupValidOut = (state_q == LOOKUP);
  assign cache_lookupAddrOut  = addr_q;
  assign cache_fillValidOut   = (state_q == FILL);
  assign cache_fillTagOut     = pend_tag;
  assign cache_fillLineOut    = line_q;
  assign mem_reqTagValidOut   = (state_q == MISS_REQ);
  assign mem_reqTagOut        = pend_tag;
  assign hitCntOut            = hit_cnt_q;
  assign missCntOut           = miss_cnt_q;

endmodule

// File: tb/tb_ifu_refill_ctrl.sv
// Self-checking bench for ifu_refill_ctrl: directed table, reset corner sequences, random transactions.
// Latency: n/a.
// Backpressure: bench stalls memory request and CPU response by table/random amounts.
module tb_ifu_refill_ctrl;

  localparam int AW  = 32;
  localparam int LW  = 128;
  localparam int TW  = 28;
  localparam int TMO = 255;

  logic          Clock = 1'b0;
  logic          Rst;
  logic          cpu_reqValidIn;
  logic          cpu_reqReadyOut;
  logic [AW-1:0] cpu_reqAddrIn;
  logic          cpu_rspValidOut;
  logic          cpu_rspReadyIn;
  logic [AW-1:0] cpu_rspAddrOut;
  logic [LW-1:0] cpu_rspInsLineOut;
  logic          cpu_rspErrOut;
  logic          cache_lookupValidOut;
  logic [AW-1:0] cache_lookupAddrOut;
  logic          cache_hitIn;
  logic [LW-1:0] cache_lineIn;
  logic          cache_fillValidOut;
  logic [TW-1:0] cache_fillTagOut;
  logic [LW-1:0] cache_fillLineOut;
  logic          mem_reqTagValidOut;
  logic          mem_reqReadyIn;
  logic [TW-1:0] mem_reqTagOut;
  logic          mem_rspInsLineValidIn;
  logic [TW-1:0] mem_rspTagIn;
  logic [LW-1:0] mem_rspInsLineIn;
  logic [15:0]   hitCntOut;
  logic [15:0]   missCntOut;

  always #5 Clock = ~Clock;

  ifu_refill_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .Clock(Clock), .Rst(Rst),
    .cpu_reqValidIn(cpu_reqValidIn), .cpu_reqReadyOut(cpu_reqReadyOut), .cpu_reqAddrIn(cpu_reqAddrIn),
    .cpu_rspValidOut(cpu_rspValidOut), .cpu_rspReadyIn(cpu_rspReadyIn), .cpu_rspAddrOut(cpu_rspAddrOut),
    .cpu_rspInsLineOut(cpu_rspInsLineOut), .cpu_rspErrOut(cpu_rspErrOut),
    .cache_lookupValidOut(cache_lookupValidOut), .cache_lookupAddrOut(cache_lookupAddrOut),
    .cache_hitIn(cache_hitIn), .cache_lineIn(cache_lineIn),
    .cache_fillValidOut(cache_fillValidOut), .cache_fillTagOut(cache_fillTagOut),
    .cache_fillLineOut(cache_fillLineOut),
    .mem_reqTagValidOut(mem_reqTagValidOut), .mem_reqReadyIn(mem_reqReadyIn), .mem_reqTagOut(mem_reqTagOut),
    .mem_rspInsLineValidIn(mem_rspInsLineValidIn), .mem_rspTagIn(mem_rspTagIn),
    .mem_rspInsLineIn(mem_rspInsLineIn),
    .hitCntOut(hitCntOut), .missCntOut(missCntOut)
  );

  typedef struct {
    logic [AW-1:0] addr;
    bit            hit;
    logic [LW-1:0] cline;
    logic [LW-1:0] mline;
    int            mem_lat;    // wait cycle (0 = first MISS_WAIT cycle) of the good memory line
    bit            bad_first;  // wrong-tag line at mem_lat, good line one cycle later
    bit            no_mem;     // memory never answers with the good tag
    int            req_stall;
    int            rsp_stall;
  } stim_t;

  typedef struct {
    logic [LW-1:0] line;
    bit            err;
    int            fills;
    int            memreqs;
    int            lat;        // hit: from accept; fill: from good line; timeout: from first wait cycle
    int            hits;
    int            misses;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int m_hits = 0;
  int m_misses = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Transaction-level reference: outcome depends only on hit/miss and when the good line shows up.
  task automatic model(input stim_t s, output exp_t e);
    int arrive;
    arrive = s.mem_lat + (s.bad_first ? 1 : 0);
    if (s.hit) begin
      m_hits    = (m_hits == 65535) ? 65535 : m_hits + 1;
      e.line    = s.cline;
      e.err     = 1'b0;
      e.fills   = 0;
      e.memreqs = 0;
      e.lat     = 2;
    end else begin
      m_misses  = (m_misses == 65535) ? 65535 : m_misses + 1;
      e.memreqs = 1;
      if (!s.no_mem && arrive <= TMO) begin
        e.line  = s.mline;
        e.err   = 1'b0;
        e.fills = 1;
        e.lat   = 2;
      end else begin
        e.line  = '0;
        e.err   = 1'b1;
        e.fills = 0;
        e.lat   = TMO + 1;
      end
    end
    e.hits   = m_hits;
    e.misses = m_misses;
  endtask

  task automatic quiet_inputs();
    cpu_reqValidIn        = 1'b0;
    cpu_reqAddrIn         = '0;
    cpu_rspReadyIn        = 1'b0;
    cache_hitIn           = 1'b0;
    cache_lineIn          = '0;
    mem_reqReadyIn        = 1'b0;
    mem_rspInsLineValidIn = 1'b0;
    mem_rspTagIn          = '0;
    mem_rspInsLineIn      = '0;
  endtask

  task automatic chk_quiet(input string n);
    chk({n, ".req_rdy"},   128'(cpu_reqReadyOut), 128'(1));
    chk({n, ".rsp_vld"},   128'(cpu_rspValidOut), 128'(0));
    chk({n, ".rsp_err"},   128'(cpu_rspErrOut), 128'(0));
    chk({n, ".lkp_vld"},   128'(cache_lookupValidOut), 128'(0));
    chk({n, ".fill_vld"},  128'(cache_fillValidOut), 128'(0));
    chk({n, ".mem_vld"},   128'(mem_reqTagValidOut), 128'(0));
    chk({n, ".hits"},      128'(hitCntOut), 128'(0));
    chk({n, ".misses"},    128'(missCntOut), 128'(0));
    chk({n, ".rsp_addr"},  128'(cpu_rspAddrOut), 128'(0));
    chk({n, ".rsp_line"},  128'(cpu_rspInsLineOut), 128'(0));
    chk({n, ".lkp_addr"},  128'(cache_lookupAddrOut), 128'(0));
    chk({n, ".fill_tag"},  128'(cache_fillTagOut), 128'(0));
    chk({n, ".fill_line"}, 128'(cache_fillLineOut), 128'(0));
    chk({n, ".mem_tag"},   128'(mem_reqTagOut), 128'(0));
  endtask

  // Entered and left #1 after a rising edge with the DUT idle.
  task automatic run_txn(input stim_t s, input exp_t e, input string n);
    int cyc, wait_entry, match_cyc, rsp_first, req_seen, rsp_seen, fills, memacc, lookups, idx, lat_ref;
    bit done, req_stable, rsp_stable, lkp_addr_ok;
    logic [TW-1:0] exp_tag, req_tag0, fill_tag;
    logic [LW-1:0] rsp_line0, fill_line;
    logic [AW-1:0] rsp_addr0;
    logic          rsp_err0;

    exp_tag = s.addr[AW-1:4];
    cyc = 0; wait_entry = -1; match_cyc = -1; rsp_first = -1;
    req_seen = 0; rsp_seen = 0; fills = 0; memacc = 0; lookups = 0;
    done = 1'b0; req_stable = 1'b1; rsp_stable = 1'b1; lkp_addr_ok = 1'b1;
    req_tag0 = '0; fill_tag = '0; fill_line = '0; rsp_line0 = '0; rsp_addr0 = '0; rsp_err0 = 1'b0;

    chk({n, ".req_rdy"}, 128'(cpu_reqReadyOut), 128'(1));
    cpu_reqValidIn = 1'b1;
    cpu_reqAddrIn  = s.addr;

    while (!done && cyc < 2000) begin
      @(posedge Clock);
      #1;
      cyc++;
      // Junk on every input; it must be ignored unless the state below overrides it.
      cpu_reqAddrIn         = $urandom;
      cpu_rspReadyIn        = 1'($urandom);
      cache_hitIn           = 1'($urandom);
      cache_lineIn          = rnd_line();
      mem_reqReadyIn        = 1'($urandom);
      mem_rspInsLineValidIn = 1'($urandom);
      mem_rspTagIn          = exp_tag;
      mem_rspInsLineIn      = rnd_line();

      if (cache_lookupValidOut) begin
        lookups++;
        if (cache_lookupAddrOut !== s.addr) lkp_addr_ok = 1'b0;
        cache_hitIn  = s.hit;
        cache_lineIn = s.cline;
      end
      if (mem_reqTagValidOut) begin
        if (req_seen == 0) req_tag0 = mem_reqTagOut;
        else if (mem_reqTagOut !== req_tag0) req_stable = 1'b0;
        mem_reqReadyIn = (req_seen >= s.req_stall);
        if (mem_reqReadyIn) begin
          memacc++;
          wait_entry = cyc + 1;
        end
        req_seen++;
      end
      if (cache_fillValidOut) begin
        fills++;
        fill_tag  = cache_fillTagOut;
        fill_line = cache_fillLineOut;
      end
      if (wait_entry >= 0 && cyc >= wait_entry) begin
        idx = cyc - wait_entry;
        mem_rspInsLineValidIn = 1'b0;
        if (s.bad_first && idx == s.mem_lat) begin
          mem_rspInsLineValidIn = 1'b1;
          mem_rspTagIn          = exp_tag ^ 28'h300;
          mem_rspInsLineIn      = ~s.mline;
        end else if (!s.no_mem && idx == s.mem_lat + (s.bad_first ? 1 : 0)) begin
          mem_rspInsLineValidIn = 1'b1;
          mem_rspTagIn          = exp_tag;
          mem_rspInsLineIn      = s.mline;
          match_cyc             = cyc;
        end
      end
      if (cpu_rspValidOut) begin
        cpu_reqValidIn = 1'b0;
        if (rsp_first < 0) begin
          rsp_first = cyc;
          rsp_line0 = cpu_rspInsLineOut;
          rsp_addr0 = cpu_rspAddrOut;
          rsp_err0  = cpu_rspErrOut;
        end else if (cpu_rspInsLineOut !== rsp_line0 || cpu_rspAddrOut !== rsp_addr0 ||
                     cpu_rspErrOut !== rsp_err0) begin
          rsp_stable = 1'b0;
        end
        cpu_rspReadyIn = (rsp_seen >= s.rsp_stall);
        rsp_seen++;
        if (cpu_rspReadyIn) done = 1'b1;
      end
    end

    chk_i({n, ".completed"}, int'(done), 1);
    @(posedge Clock);
    #1;
    quiet_inputs();

    lat_ref = s.hit ? 0 : (e.err ? wait_entry : match_cyc);
    chk_i({n, ".lookups"}, lookups, 1);
    chk_i({n, ".lkp_addr"}, int'(lkp_addr_ok), 1);
    chk_i({n, ".mem_reqs"}, memacc, e.memreqs);
    if (e.memreqs > 0) begin
      chk({n, ".mem_tag"}, 128'(req_tag0), 128'(exp_tag));
      chk_i({n, ".mem_stable"}, int'(req_stable), 1);
      chk_i({n, ".mem_cycles"}, req_seen, s.req_stall + 1);
    end
    chk_i({n, ".fills"}, fills, e.fills);
    if (e.fills > 0) begin
      chk({n, ".fill_tag"}, 128'(fill_tag), 128'(exp_tag));
      chk({n, ".fill_line"}, fill_line, s.mline);
    end
    chk({n, ".rsp_line"}, rsp_line0, e.line);
    chk({n, ".rsp_addr"}, 128'(rsp_addr0), 128'(s.addr));
    chk({n, ".rsp_err"}, 128'(rsp_err0), 128'(e.err));
    chk_i({n, ".latency"}, rsp_first - lat_ref, e.lat);
    chk_i({n, ".rsp_stable"}, int'(rsp_stable), 1);
    chk_i({n, ".rsp_cycles"}, rsp_seen, s.rsp_stall + 1);
    chk({n, ".hits"}, 128'(hitCntOut), 128'(e.hits));
    chk({n, ".misses"}, 128'(missCntOut), 128'(e.misses));
  endtask

  function automatic vec_t mk(input logic [AW-1:0] addr, input bit hit, input logic [LW-1:0] cline,
                              input logic [LW-1:0] mline, input int lat, input bit bad, input bit nomem,
                              input int rqs, input int rss, input logic [LW-1:0] eline, input bit eerr,
                              input int efill, input int emem, input int elat, input int eh, input int em);
    vec_t v;
    v.s.addr = addr; v.s.hit = hit; v.s.cline = cline; v.s.mline = mline; v.s.mem_lat = lat;
    v.s.bad_first = bad; v.s.no_mem = nomem; v.s.req_stall = rqs; v.s.rsp_stall = rss;
    v.e.line = eline; v.e.err = eerr; v.e.fills = efill; v.e.memreqs = emem; v.e.lat = elat;
    v.e.hits = eh; v.e.misses = em;
    return v;
  endfunction

  localparam logic [LW-1:0] L_A5 = 128'hA5A5A5A5;
  localparam logic [LW-1:0] L_DB = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [LW-1:0] L_2  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [LW-1:0] L_3  = 128'hCAFEF00D_0BADC0DE_13579BDF_2468ACE0;
  localparam logic [LW-1:0] L_1S = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
  localparam logic [LW-1:0] L_5  = 128'h5A5A0000_11112222_33334444_55556666;
  localparam logic [LW-1:0] L_X  = 128'h99999999_88888888_77777777_66666666;

  vec_t  vecs[8];
  stim_t rs;
  exp_t  re;

  initial begin
    //               addr          hit cline mline lat bad nom rqs rss eline eerr fill mem lat  hits miss
    vecs[0] = mk(32'h0000_1000, 1, L_A5, L_X,   3, 0, 0, 0, 0, L_A5, 0, 0, 0,   2, 1, 0);
    vecs[1] = mk(32'h0000_1000, 0, L_X,  L_DB,  3, 0, 0, 0, 0, L_DB, 0, 1, 1,   2, 1, 1);
    vecs[2] = mk(32'h0000_1000, 0, L_X,  L_2,   2, 1, 0, 0, 0, L_2,  0, 1, 1,   2, 1, 2);
    vecs[3] = mk(32'h0000_2340, 0, L_X,  L_3,   0, 0, 0, 5, 3, L_3,  0, 1, 1,   2, 1, 3);
    vecs[4] = mk(32'hFFFF_FFF0, 1, L_1S, L_X,   0, 0, 0, 0, 3, L_1S, 0, 0, 0,   2, 2, 3);
    vecs[5] = mk(32'h0000_0010, 0, L_X,  L_5, 255, 0, 0, 1, 0, L_5,  0, 1, 1,   2, 2, 4);
    vecs[6] = mk(32'h8000_0000, 0, L_X,  L_5, 256, 0, 0, 0, 1, '0,   1, 0, 1, 256, 2, 5);
    vecs[7] = mk(32'h0000_1000, 0, L_X,  L_DB,  0, 0, 1, 0, 0, '0,   1, 0, 1, 256, 2, 6);

    quiet_inputs();
    Rst = 1'b0;
    #3;
    chk_quiet("reset");
    repeat (2) @(posedge Clock);
    #1;
    chk_quiet("reset_clk");
    Rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].s, vecs[i].e, $sformatf("vec%0d", i));
    end

    // Reset while waiting on memory; a late line afterwards must not revive the transaction.
    cpu_reqValidIn = 1'b1;
    cpu_reqAddrIn  = 32'h0000_1000;
    @(posedge Clock); #1;
    cpu_reqValidIn = 1'b0;
    cache_hitIn    = 1'b0;
    @(posedge Clock); #1;
    chk("rst_wait.mem_vld", 128'(mem_reqTagValidOut), 128'(1));
    mem_reqReadyIn = 1'b1;
    @(posedge Clock); #1;
    mem_reqReadyIn = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_wait.in_wait", 128'({mem_reqTagValidOut, cpu_rspValidOut, cpu_reqReadyOut}), 128'(0));
    chk("rst_wait.misses", 128'(missCntOut), 128'(7));
    Rst = 1'b0;
    #1;
    chk_quiet("rst_wait.async");
    @(posedge Clock); #1;
    Rst = 1'b1;
    mem_rspInsLineValidIn = 1'b1;
    mem_rspTagIn          = 28'h100;
    mem_rspInsLineIn      = L_DB;
    @(posedge Clock); #1;
    mem_rspInsLineValidIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_quiet($sformatf("rst_late%0d", i));
      @(posedge Clock); #1;
    end

    m_hits   = 0;
    m_misses = 0;
    for (int i = 0; i < 40; i++) begin
      rs.addr      = $urandom;
      rs.hit       = 1'($urandom_range(0, 1));
      rs.cline     = rnd_line();
      rs.mline     = rnd_line();
      rs.mem_lat   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(253, 257)) : int'($urandom_range(0, 6));
      rs.bad_first = 1'($urandom_range(0, 1));
      rs.no_mem    = ($urandom_range(0, 19) == 0);
      rs.req_stall = int'($urandom_range(0, 4));
      rs.rsp_stall = int'($urandom_range(0, 4));
      model(rs, re);
      run_txn(rs, re, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
